// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_pkg
// Description : Shared constants and state encoding for the USB TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    localparam logic [3:0] c_PID_NONE  = 4'd0;
    localparam logic [3:0] c_PID_ACK   = 4'd2;
    localparam logic [3:0] c_PID_NAK   = 4'd10;
    localparam logic [3:0] c_PID_STALL = 4'd14;
    localparam logic [3:0] c_PID_DATA0 = 4'd3;
    localparam logic [3:0] c_PID_DATA1 = 4'd11;

    localparam logic [1:0] c_HS_ACK   = 2'd0;
    localparam logic [1:0] c_HS_NAK   = 2'd1;
    localparam logic [1:0] c_HS_STALL = 2'd2;
    localparam logic [1:0] c_HS_RSVD  = 2'd3;

    localparam logic [6:0] c_MAX_PAYLOAD = 7'd64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_GAP        = 3'd4
    } tx_state_e;

    function automatic logic [3:0] hs_pid(input logic [1:0] hs_kind);
        case (hs_kind)
            c_HS_ACK:   return c_PID_ACK;
            c_HS_NAK:   return c_PID_NAK;
            c_HS_STALL: return c_PID_STALL;
            default:    return c_PID_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_gap_timer
// Description : Loadable down-counter shared by start timeout and IPG gap.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_gap_timer
    import usb_tx_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Saturates at zero so an idle timer never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_arbiter
// Description : Arbitrates handshake and data packet requests onto USB TX.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int IPG_CYCLES    = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [1:0] hs_type,
    output logic       hs_done,
    input  logic       data_req,
    input  logic [6:0] data_len,
    output logic       data_done,
    output logic       data_err,
    input  logic       toggle_ack,
    input  logic       toggle_reset,
    input  logic [6:0] Buffer_Occupancy,
    input  logic       TX_Transfer_Active,
    input  logic       TX_Error,
    output logic [3:0] TX_Packet,
    output logic       busy
);

    localparam int c_CNT_MAX = (IPG_CYCLES > START_TIMEOUT) ? IPG_CYCLES : START_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    // Timeout is measured from the issue cycle, so WAIT_START gets one less.
    localparam logic [c_CNT_W-1:0] c_START_LOAD = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'(IPG_CYCLES);

    tx_state_e          r_state, w_next_state;
    logic               r_win_data, r_fail, r_toggle;
    logic [1:0]         r_win_hs_type;
    logic               r_hs_done, r_data_done, r_data_err;
    logic               w_hs_ok, w_hs_bad, w_data_ok, w_data_bad;
    logic               w_latch, w_tmr_load, w_tmr_expired;
    logic [c_CNT_W-1:0] w_tmr_value;
    logic               w_hs_done, w_data_done, w_data_err;

    // A request whose done pulse is currently visible is not re-arbitrated.
    assign w_hs_ok    = hs_req && !r_hs_done && (hs_type != c_HS_RSVD);
    assign w_hs_bad   = hs_req && !r_hs_done && (hs_type == c_HS_RSVD);
    assign w_data_ok  = data_req && !r_data_done && (data_len <= c_MAX_PAYLOAD)
                        && (Buffer_Occupancy >= data_len);
    assign w_data_bad = data_req && !r_data_done && (data_len > c_MAX_PAYLOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:       if (w_hs_ok || w_data_ok) w_next_state = ST_ISSUE;
            ST_ISSUE:      w_next_state = ST_WAIT_START;
            ST_WAIT_START: begin
                if (TX_Transfer_Active)  w_next_state = ST_ACTIVE;
                else if (w_tmr_expired)  w_next_state = ST_GAP;
            end
            ST_ACTIVE:     if (!TX_Transfer_Active) w_next_state = ST_GAP;
            ST_GAP:        if (w_tmr_expired) w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        TX_Packet   = c_PID_NONE;
        busy        = (r_state != ST_IDLE);
        w_latch     = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_value = c_GAP_LOAD;
        w_hs_done   = 1'b0;
        w_data_done = 1'b0;
        w_data_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_latch   = w_hs_ok || w_data_ok;
                w_hs_done = w_hs_bad;
                if (w_data_bad && !w_hs_ok) begin
                    w_data_done = 1'b1;
                    w_data_err  = 1'b1;
                end
            end
            ST_ISSUE: begin
                TX_Packet   = r_win_data ? (r_toggle ? c_PID_DATA1 : c_PID_DATA0)
                                         : hs_pid(r_win_hs_type);
                w_tmr_load  = 1'b1;
                w_tmr_value = c_START_LOAD;
            end
            ST_WAIT_START: begin
                if (!TX_Transfer_Active && w_tmr_expired) begin
                    w_tmr_load  = 1'b1;
                    w_hs_done   = !r_win_data;
                    w_data_done = r_win_data;
                    w_data_err  = r_win_data;
                end
            end
            ST_ACTIVE: begin
                if (!TX_Transfer_Active) begin
                    w_tmr_load  = 1'b1;
                    w_hs_done   = !r_win_data;
                    w_data_done = r_win_data;
                    w_data_err  = r_win_data && (r_fail || TX_Error);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_data    <= 1'b0;
            r_win_hs_type <= c_HS_ACK;
            r_fail        <= 1'b0;
            r_hs_done     <= 1'b0;
            r_data_done   <= 1'b0;
            r_data_err    <= 1'b0;
        end else begin
            r_hs_done   <= w_hs_done;
            r_data_done <= w_data_done;
            r_data_err  <= w_data_err;
            if (w_latch) begin
                r_win_data    <= !w_hs_ok;
                r_win_hs_type <= hs_type;
                r_fail        <= 1'b0;
            end else if (TX_Error && (r_state == ST_WAIT_START || r_state == ST_ACTIVE)) begin
                r_fail <= 1'b1;
            end
        end
    end

    // Clear has priority over flip when both pulse together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle <= 1'b0;
        end else if (toggle_reset) begin
            r_toggle <= 1'b0;
        end else if (toggle_ack) begin
            r_toggle <= !r_toggle;
        end
    end

    usb_tx_gap_timer #(
        .WIDTH(c_CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_tmr_load),
        .load_value (w_tmr_value),
        .expired    (w_tmr_expired)
    );

    assign hs_done   = r_hs_done;
    assign data_done = r_data_done;
    assign data_err  = r_data_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_arbiter
// Description : Directed and randomized checks of usb_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_arbiter;

    localparam int IPG     = 16;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hs_req = 1'b0, data_req = 1'b0;
    logic [1:0] hs_type = 2'd0;
    logic [6:0] data_len = 7'd0, Buffer_Occupancy = 7'd0;
    logic       toggle_ack = 1'b0, toggle_reset = 1'b0;
    logic       TX_Transfer_Active = 1'b0, TX_Error = 1'b0;
    logic       hs_done, data_done, data_err, busy;
    logic [3:0] TX_Packet;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_toggle = 1'b0;

    usb_tx_arbiter #(
        .IPG_CYCLES    (IPG),
        .START_TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .hs_req             (hs_req),
        .hs_type            (hs_type),
        .hs_done            (hs_done),
        .data_req           (data_req),
        .data_len           (data_len),
        .data_done          (data_done),
        .data_err           (data_err),
        .toggle_ack         (toggle_ack),
        .toggle_reset       (toggle_reset),
        .Buffer_Occupancy   (Buffer_Occupancy),
        .TX_Transfer_Active (TX_Transfer_Active),
        .TX_Error           (TX_Error),
        .TX_Packet          (TX_Packet),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_toggle(input bit ack, input bit clr);
        toggle_ack   = ack;
        toggle_reset = clr;
        tick();
        toggle_ack   = 1'b0;
        toggle_reset = 1'b0;
        if (clr)      m_toggle = 1'b0;
        else if (ack) m_toggle = ~m_toggle;
    endtask

    // Starts in an IDLE cycle with the winning request presented; models the
    // TX datapath (rise d cycles after issue, high len_act cycles; d<0 never).
    task automatic do_xfer(input bit is_data, input logic [1:0] ht, input int d,
                           input int len_act, input int errpos, input bit drop_req);
        int         done_at;
        logic [3:0] exp_pid;
        bit         exp_err;
        bit         bad;
        if (is_data)          exp_pid = m_toggle ? 4'd11 : 4'd3;
        else if (ht == 2'd0)  exp_pid = 4'd2;
        else if (ht == 2'd1)  exp_pid = 4'd10;
        else                  exp_pid = 4'd14;
        done_at = (d < 0) ? TIMEOUT : d + len_act + 1;
        exp_err = is_data && (d < 0 || errpos >= 0);
        tick();
        chk("issue_pid", 32'(TX_Packet), 32'(exp_pid));
        chk("issue_busy", 32'(busy), 32'd1);
        bad = 1'b0;
        for (int k = 1; k <= done_at; k++) begin
            tick();
            if (drop_req && k == 1) begin
                if (is_data) data_req = 1'b0;
                else         hs_req   = 1'b0;
            end
            TX_Transfer_Active = (d >= 0) && (k >= d) && (k < d + len_act);
            TX_Error           = (d >= 0) && (errpos >= 0) && (k == d + errpos);
            if (k < done_at && (hs_done || data_done || data_err || TX_Packet != 4'd0 || !busy))
                bad = 1'b1;
        end
        chk("no_early_done", 32'(bad), 32'd0);
        chk("hs_done", 32'(hs_done), 32'(!is_data));
        chk("data_done", 32'(data_done), 32'(is_data));
        chk("data_err", 32'(data_err), 32'(exp_err));
        if (is_data) data_req = 1'b0;
        else         hs_req   = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= IPG; k++) begin
            tick();
            if (hs_done || data_done || data_err || TX_Packet != 4'd0) bad = 1'b1;
            if (k < IPG && !busy) bad = 1'b1;
        end
        chk("gap_quiet", 32'(bad), 32'd0);
        chk("gap_end_idle", 32'(busy), 32'd0);
    endtask

    task automatic rand_xfer(input bit is_data, input logic [1:0] ht);
        int d, l, e;
        d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TIMEOUT - 1));
        l = int'($urandom_range(1, 12));
        e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
        do_xfer(is_data, ht, d, l, e, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int  kind;
        bit  bad;
        // Reset state, asserted asynchronously before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_pid", 32'(TX_Packet), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hs_done", 32'(hs_done), 32'd0);
        chk("rst_data_done", 32'(data_done), 32'd0);
        chk("rst_data_err", 32'(data_err), 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Basic data packet.
        data_req = 1'b1; data_len = 7'd8; Buffer_Occupancy = 7'd8;
        do_xfer(1'b1, 2'd0, 3, 20, -1, 1'b0);

        // Handshake beats data in the same cycle; data follows after the gap.
        hs_req = 1'b1; hs_type = 2'd0; data_req = 1'b1;
        do_xfer(1'b0, 2'd0, 2, 4, -1, 1'b0);
        do_xfer(1'b1, 2'd0, 1, 5, -1, 1'b0);

        // Data toggle flip, then clear winning over flip.
        pulse_toggle(1'b1, 1'b0);
        data_req = 1'b1;
        do_xfer(1'b1, 2'd0, 2, 6, -1, 1'b0);
        pulse_toggle(1'b1, 1'b1);
        data_req = 1'b1;
        do_xfer(1'b1, 2'd0, 2, 6, 2, 1'b0);

        // Start timeout, NAK and STALL handshakes.
        data_req = 1'b1;
        do_xfer(1'b1, 2'd0, -1, 1, -1, 1'b0);
        hs_req = 1'b1; hs_type = 2'd1;
        do_xfer(1'b0, 2'd1, 4, 3, 1, 1'b1);
        hs_req = 1'b1; hs_type = 2'd2;
        do_xfer(1'b0, 2'd2, -1, 1, -1, 1'b0);

        // Oversized payload and reserved handshake: immediate pulses, no packet.
        data_req = 1'b1; data_len = 7'd65;
        tick();
        chk("len65_done", 32'(data_done), 32'd1);
        chk("len65_err", 32'(data_err), 32'd1);
        chk("len65_pid", 32'(TX_Packet), 32'd0);
        data_req = 1'b0;
        tick();
        chk("len65_pulse_end", 32'(data_done), 32'd0);
        chk("len65_no_issue", 32'(TX_Packet), 32'd0);
        hs_req = 1'b1; hs_type = 2'd3;
        tick();
        chk("rsvd_hs_done", 32'(hs_done), 32'd1);
        chk("rsvd_busy", 32'(busy), 32'd0);
        hs_req = 1'b0;
        tick();
        chk("rsvd_pulse_end", 32'(hs_done), 32'd0);
        chk("rsvd_no_issue", 32'(TX_Packet), 32'd0);

        // Insufficient occupancy holds off, then issues once it suffices.
        data_req = 1'b1; data_len = 7'd8; Buffer_Occupancy = 7'd4;
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (TX_Packet != 4'd0 || busy || data_done) bad = 1'b1;
        end
        chk("low_occ_wait", 32'(bad), 32'd0);
        Buffer_Occupancy = 7'd8;
        do_xfer(1'b1, 2'd0, 1, 3, -1, 1'b0);

        // Reset during ACTIVE: outputs clear, no done, request re-arbitrates.
        pulse_toggle(1'b1, 1'b0);
        data_req = 1'b1;
        tick();
        chk("pre_rst_pid", 32'(TX_Packet), 32'(m_toggle ? 4'd11 : 4'd3));
        tick();
        TX_Transfer_Active = 1'b1;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pid", 32'(TX_Packet), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(data_done), 32'd0);
        TX_Transfer_Active = 1'b0;
        m_toggle = 1'b0;
        tick();
        chk("rst_no_done", 32'(data_done), 32'd0);
        rst = 1'b0;
        do_xfer(1'b1, 2'd0, 3, 4, -1, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0)
                pulse_toggle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            kind = int'($urandom_range(0, 2));
            if (kind != 1) begin
                hs_type = 2'($urandom_range(0, 2));
                hs_req  = 1'b1;
            end
            if (kind != 0) begin
                data_len         = 7'($urandom_range(0, 64));
                Buffer_Occupancy = 7'($urandom_range(int'(data_len), 127));
                data_req         = 1'b1;
            end
            if (kind != 1) rand_xfer(1'b0, hs_type);
            if (kind != 0) rand_xfer(1'b1, 2'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 Parameter IPG_CYCLES, default 16, minimum idle cycles between end of one transmission and the next TX_Packet issue.
REQ-002 Parameter START_TIMEOUT, default 8, maximum cycles from TX_Packet issue to TX_Transfer_Active rising.
REQ-003 clk  in  1  single clock; all logic rising-edge; one clock, reset is asynchronous and active-high.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 hs_req  in  1  handshake request, level, held until hs_done.
REQ-006 hs_type  in  2  handshake kind: 0 ACK, 1 NAK, 2 STALL, 3 reserved.
REQ-007 hs_done  out  1  one-cycle pulse, handshake transmission finished.
REQ-008 data_req  in  1  data-packet request, level, held until data_done.
REQ-009 data_len  in  7  payload bytes, legal 0..64.
REQ-010 data_done  out  1  one-cycle pulse, data request finished (success or error).
REQ-011 data_err  out  1  one-cycle pulse coincident with data_done on failure.
REQ-012 toggle_ack  in  1  pulse: host ACKed last DATA packet, flip data toggle.
REQ-013 toggle_reset  in  1  pulse: force data toggle to DATA0.
REQ-014 Buffer_Occupancy  in  7  bytes currently in TX FIFO.
REQ-015 TX_Transfer_Active  in  1  from TX datapath, high while packet is on the bus.
REQ-016 TX_Error  in  1  from TX datapath, transmission error.
REQ-017 TX_Packet  out  4  packet command to TX datapath; 0 = none.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States IDLE, ISSUE, WAIT_START, ACTIVE, GAP; one-hot or binary at implementer's choice.
REQ-020 Eligibility: hs_req with hs_type!=3; data_req with data_len<=64 and Buffer_Occupancy>=data_len.
REQ-021 IDLE: if any eligible, latch winner (handshake has fixed priority over data) and go to ISSUE next cycle.
REQ-022 hs_type==3 while hs_req in IDLE: hs_done pulse, no transmission, stay IDLE.
REQ-023 data_len>64 while data_req in IDLE (and no eligible hs): data_done+data_err pulse, no transmission.
REQ-024 ISSUE: drive TX_Packet for exactly one cycle: ACK=2, NAK=10, STALL=14, DATA0=3, DATA1=11 (toggle selects); go WAIT_START. TX_Packet=0 in all other cycles.
REQ-025 WAIT_START: counter from 0; TX_Transfer_Active high -> ACTIVE; counter reaching START_TIMEOUT -> done pulse (+data_err if data) and GAP.
REQ-026 ACTIVE: TX_Transfer_Active falling -> done pulse for winner, GAP; TX_Error seen in WAIT_START or ACTIVE marks failure (data_err for data; hs_done only for handshake).
REQ-027 GAP: count IPG_CYCLES cycles then IDLE; requests not arbitrated during GAP.
REQ-028 Requester dropping req mid-transfer is ignored; transfer completes and done still pulses.
REQ-029 Data toggle: reset 0; toggle_ack flips; toggle_reset clears; simultaneous -> clear wins; sampled at ISSUE only.
REQ-030 Buffer_Occupancy checked only in IDLE; later changes do not abort a transfer.
REQ-031 Counters sized to max(IPG_CYCLES, START_TIMEOUT); no wrap inside a state.

Reset
REQ-032 rst asserted: state IDLE, counters 0, toggle 0, latched winner cleared; TX_Packet=0, hs_done=0, data_done=0, data_err=0, busy=0, immediately and asynchronously.
REQ-033 rst mid-transfer: no done pulse issued for the aborted request; after release, a still-held request re-arbitrates from IDLE.

Structure
REQ-034 Package usb_tx_pkg holds TX_Packet command constants, hs_type encoding, state enum, max payload 64.
REQ-035 One sub-module usb_tx_gap_timer: loadable down-counter shared by WAIT_START timeout and GAP.

Verification
REQ-036 data_req, data_len=8, occupancy=8, active high 3 cycles after issue for 20 cycles -> TX_Packet=3 one cycle, data_done 1 cycle after fall, busy low 16 cycles later.
REQ-037 hs_req(ACK) and data_req eligible same cycle -> TX_Packet=2 first; DATA issued only after hs_done + 16-cycle gap.
REQ-038 toggle_ack after data transfer, second data_req -> TX_Packet=11; toggle_ack+toggle_reset together -> next is 3.
REQ-039 TX_Transfer_Active never rises -> data_done+data_err 8 cycles after issue; data_len=65 -> immediate data_done+data_err, TX_Packet stays 0.
REQ-040 occupancy=4, data_len=8 -> no issue; occupancy to 8 -> issue next IDLE cycle; rst during ACTIVE -> outputs 0, no done pulse.
